// File: rtl/snax_mac_periph_regfile_pkg.sv
// Shared definitions for the SNAX MAC peripheral register file: register offsets,
// job FSM states and the configuration record. Optional perf counter: SNAX_MAC_PERF_CNT_EN.
package snax_mac_regfile_pkg;

   localparam logic [4:0] REG_CTRL   = 5'h00;
   localparam logic [4:0] REG_STATUS = 5'h04;
   localparam logic [4:0] REG_SRC_A  = 5'h08;
   localparam logic [4:0] REG_SRC_B  = 5'h0C;
   localparam logic [4:0] REG_DST    = 5'h10;
   localparam logic [4:0] REG_LEN    = 5'h14;
   localparam logic [4:0] REG_MODE   = 5'h18;
   localparam logic [4:0] REG_PERF   = 5'h1C;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2
   } job_state_e;

   // len/mode are kept 32 bits wide here; the top masks them to their significant width.
   typedef struct packed {
      logic [31:0] src_a;
      logic [31:0] src_b;
      logic [31:0] dst;
      logic [31:0] len;
      logic [31:0] mode;
   } mac_cfg_t;

   function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                            input logic [31:0] wdata,
                                            input logic [3:0]  be);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[b*8 +: 8] = be[b] ? wdata[b*8 +: 8] : old_val[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/snax_mac_periph_regfile_if.sv
// HWPE periph bus (req/gnt with a single r_valid response per granted request).
interface snax_mac_periph_regfile_if #(
   parameter int unsigned IdWidth = 5
);
   logic               req;
   logic               gnt;
   logic [31:0]        add;
   logic               wen;
   logic [3:0]         be;
   logic [31:0]        data;
   logic [IdWidth-1:0] id;
   logic               r_valid;
   logic [31:0]        r_data;
   logic [IdWidth-1:0] r_id;

   modport master (
      output req, add, wen, be, data, id,
      input  gnt, r_valid, r_data, r_id
   );

   modport slave (
      input  req, add, wen, be, data, id,
      output gnt, r_valid, r_data, r_id
   );
endinterface

// File: rtl/snax_mac_job_fsm.sv
// Job-control FSM: start pulse, busy tracking, sticky done/err flags and the
// optional cycle counter enabled by SNAX_MAC_PERF_CNT_EN.
module snax_mac_job_fsm
   import snax_mac_regfile_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        trigger_i,
   input  logic        len_zero_i,
   input  logic        err_set_i,
   input  logic        status_rd_i,
   input  logic        done_i,
   output logic        start_o,
   output logic        busy_o,
   output logic        done_flag_o,
   output logic        err_flag_o,
   output logic [31:0] perf_o
);

   job_state_e state_reg, state_next;
   logic       done_reg, done_next, done_set;
   logic       err_reg, err_next;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= IDLE;
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         done_reg  <= done_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      done_set   = 1'b0;
      start_o    = 1'b0;
      busy_o     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (trigger_i) begin
               if (len_zero_i) done_set   = 1'b1;
               else            state_next = START;
            end
         end
         START: begin
            start_o    = 1'b1;
            busy_o     = 1'b1;
            state_next = BUSY;
         end
         BUSY: begin
            busy_o = 1'b1;
            if (done_i) begin
               state_next = IDLE;
               done_set   = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
      // A set in the same cycle as a STATUS read wins over the read-clear.
      done_next = done_set  | (done_reg & ~status_rd_i);
      err_next  = err_set_i | (err_reg  & ~status_rd_i);
   end

   assign done_flag_o = done_reg;
   assign err_flag_o  = err_reg;

`ifdef SNAX_MAC_PERF_CNT_EN
   logic [31:0] perf_reg;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_reg <= '0;
      end else if (state_reg == IDLE && state_next == START) begin
         perf_reg <= '0;
      end else if (state_reg != IDLE && perf_reg != 32'hFFFF_FFFF) begin
         perf_reg <= perf_reg + 32'd1;
      end
   end

   assign perf_o = perf_reg;
`else
   assign perf_o = '0;
`endif

endmodule

// File: rtl/snax_mac_periph_regfile.sv
// Periph-bus slave for the SNAX MAC: address decode, configuration storage and the
// one-cycle response pipeline. PERF counter is built only with SNAX_MAC_PERF_CNT_EN.
module snax_mac_periph_regfile
   import snax_mac_regfile_pkg::*;
#(
   parameter int unsigned IdWidth   = 5,
   parameter int unsigned LenWidth  = 16,
   parameter int unsigned ModeWidth = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   snax_mac_periph_regfile_if.slave periph,
   output logic                 start_o,
   output logic [31:0]          src_a_o,
   output logic [31:0]          src_b_o,
   output logic [31:0]          dst_o,
   output logic [LenWidth-1:0]  len_o,
   output logic [ModeWidth-1:0] mode_o,
   output logic                 busy_o,
   input  logic                 done_i
);

   localparam logic [31:0] LenMask  = (LenWidth  >= 32) ? 32'hFFFF_FFFF : ((32'd1 << LenWidth)  - 32'd1);
   localparam logic [31:0] ModeMask = (ModeWidth >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ModeWidth) - 32'd1);

   mac_cfg_t           cfg_reg, cfg_next;
   logic               r_valid_reg;
   logic [31:0]        r_data_reg, r_data_next;
   logic [IdWidth-1:0] r_id_reg;

   logic        in_range, cfg_sel, trigger, err_set, status_rd;
   logic        busy, done_flag, err_flag;
   logic [31:0] perf;
   logic [4:0]  off;
   logic        unused_add;

   assign in_range   = (periph.add[31:5] == '0);
   assign off        = {periph.add[4:2], 2'b00};
   assign cfg_sel    = (off >= REG_SRC_A) && (off <= REG_MODE);
   assign unused_add = ^periph.add[1:0];

   always_comb begin
      cfg_next    = cfg_reg;
      trigger     = 1'b0;
      err_set     = 1'b0;
      status_rd   = 1'b0;
      r_data_next = '0;
      if (periph.req && !in_range) begin
         err_set = 1'b1;
      end else if (periph.req && !periph.wen) begin
         if (off == REG_CTRL && periph.data[0]) begin
            if (busy) err_set = 1'b1;
            else      trigger = 1'b1;
         end
         // Configuration is frozen while a job is in flight.
         if (cfg_sel) begin
            if (busy) begin
               err_set = 1'b1;
            end else begin
               case (off)
                  REG_SRC_A: cfg_next.src_a = be_merge(cfg_reg.src_a, periph.data, periph.be);
                  REG_SRC_B: cfg_next.src_b = be_merge(cfg_reg.src_b, periph.data, periph.be);
                  REG_DST:   cfg_next.dst   = be_merge(cfg_reg.dst,   periph.data, periph.be);
                  REG_LEN:   cfg_next.len   = be_merge(cfg_reg.len,   periph.data, periph.be) & LenMask;
                  REG_MODE:  cfg_next.mode  = be_merge(cfg_reg.mode,  periph.data, periph.be) & ModeMask;
                  default:   cfg_next       = cfg_reg;
               endcase
            end
         end
      end else if (periph.req) begin
         case (off)
            REG_STATUS: begin
               r_data_next = {29'd0, err_flag, done_flag, busy};
               status_rd   = 1'b1;
            end
            REG_SRC_A: r_data_next = cfg_reg.src_a;
            REG_SRC_B: r_data_next = cfg_reg.src_b;
            REG_DST:   r_data_next = cfg_reg.dst;
            REG_LEN:   r_data_next = cfg_reg.len;
            REG_MODE:  r_data_next = cfg_reg.mode;
            REG_PERF:  r_data_next = perf;
            default:   r_data_next = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cfg_reg     <= '0;
         r_valid_reg <= 1'b0;
         r_data_reg  <= '0;
         r_id_reg    <= '0;
      end else begin
         cfg_reg     <= cfg_next;
         r_valid_reg <= periph.req;
         r_data_reg  <= r_data_next;
         r_id_reg    <= periph.id;
      end
   end

   snax_mac_job_fsm u_job_fsm (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .trigger_i   (trigger),
      .len_zero_i  (cfg_reg.len == '0),
      .err_set_i   (err_set),
      .status_rd_i (status_rd),
      .done_i      (done_i),
      .start_o     (start_o),
      .busy_o      (busy),
      .done_flag_o (done_flag),
      .err_flag_o  (err_flag),
      .perf_o      (perf)
   );

   assign periph.gnt     = periph.req;
   assign periph.r_valid = r_valid_reg;
   assign periph.r_data  = r_data_reg;
   assign periph.r_id    = r_id_reg;

   assign busy_o  = busy;
   assign src_a_o = cfg_reg.src_a;
   assign src_b_o = cfg_reg.src_b;
   assign dst_o   = cfg_reg.dst;
   assign len_o   = cfg_reg.len[LenWidth-1:0];
   assign mode_o  = cfg_reg.mode[ModeWidth-1:0];

endmodule

// File: tb/tb_snax_mac_periph_regfile.sv
// Directed bench for snax_mac_periph_regfile: register table, job sequencing,
// flag corner cases, back-to-back responses and asynchronous reset mid-job.
module tb_snax_mac_periph_regfile;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        start_o, busy_o, done_i;
   logic [31:0] src_a_o, src_b_o, dst_o;
   logic [15:0] len_o;
   logic [1:0]  mode_o;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int start_cnt = 0;

   snax_mac_periph_regfile_if #(.IdWidth(5)) periph ();

   snax_mac_periph_regfile #(.IdWidth(5), .LenWidth(16), .ModeWidth(2)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_ni),
      .periph  (periph.slave),
      .start_o (start_o),
      .src_a_o (src_a_o),
      .src_b_o (src_b_o),
      .dst_o   (dst_o),
      .len_o   (len_o),
      .mode_o  (mode_o),
      .busy_o  (busy_o),
      .done_i  (done_i)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) if (start_o === 1'b1) start_cnt++;

   typedef struct {
      logic        wen;
      logic [31:0] add;
      logic [31:0] data;
      logic [3:0]  be;
      logic [4:0]  id;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic txn(input logic wen, input logic [31:0] add, input logic [31:0] data,
                      input logic [3:0] be, input logic [4:0] id, input logic with_done,
                      output logic [31:0] rdata, output logic [4:0] rid, output logic rvalid,
                      output logic gnt);
      @(negedge clk);
      periph.req  = 1'b1;
      periph.wen  = wen;
      periph.add  = add;
      periph.data = data;
      periph.be   = be;
      periph.id   = id;
      done_i      = with_done;
      #1 gnt = periph.gnt;
      @(negedge clk);
      periph.req = 1'b0;
      done_i     = 1'b0;
      rvalid     = periph.r_valid;
      rdata      = periph.r_data;
      rid        = periph.r_id;
   endtask

   task automatic rd(input logic [31:0] add, input string name, input logic [31:0] exp);
      logic [31:0] rdata;
      logic [4:0]  rid;
      logic        rvalid, gnt;
      txn(1'b1, add, 32'h0, 4'h0, 5'd9, 1'b0, rdata, rid, rvalid, gnt);
      check({name, " r_valid"}, {31'd0, rvalid}, 32'd1);
      check(name, rdata, exp);
   endtask

   task automatic wr(input logic [31:0] add, input logic [31:0] data, input logic [3:0] be);
      logic [31:0] rdata;
      logic [4:0]  rid;
      logic        rvalid, gnt;
      txn(1'b0, add, data, be, 5'd10, 1'b0, rdata, rid, rvalid, gnt);
   endtask

   initial begin
      logic [31:0] rdata;
      logic [4:0]  rid;
      logic        rvalid, gnt;
      int          t_start, t_end, perf_exp, m;

      vecs[0]  = '{1'b0, 32'h08, 32'h0000_1000, 4'hF, 5'd3,  32'h0};
      vecs[1]  = '{1'b1, 32'h08, 32'h0,         4'h0, 5'd4,  32'h0000_1000};
      vecs[2]  = '{1'b0, 32'h0C, 32'hDEAD_BEEF, 4'h5, 5'd1,  32'h0};
      vecs[3]  = '{1'b1, 32'h0C, 32'h0,         4'h0, 5'd2,  32'h00AD_00EF};
      vecs[4]  = '{1'b0, 32'h10, 32'h1234_5678, 4'hF, 5'd5,  32'h0};
      vecs[5]  = '{1'b0, 32'h10, 32'hFFFF_FFFF, 4'h8, 5'd6,  32'h0};
      vecs[6]  = '{1'b1, 32'h10, 32'h0,         4'h0, 5'd7,  32'hFF34_5678};
      vecs[7]  = '{1'b0, 32'h14, 32'hABCD_0008, 4'hF, 5'd8,  32'h0};
      vecs[8]  = '{1'b1, 32'h14, 32'h0,         4'h0, 5'd31, 32'h0000_0008};
      vecs[9]  = '{1'b0, 32'h18, 32'hFFFF_FFFF, 4'hF, 5'd11, 32'h0};
      vecs[10] = '{1'b1, 32'h18, 32'h0,         4'h0, 5'd12, 32'h0000_0003};
      vecs[11] = '{1'b1, 32'h00, 32'h0,         4'h0, 5'd13, 32'h0};
      vecs[12] = '{1'b1, 32'h04, 32'h0,         4'h0, 5'd14, 32'h0};
      vecs[13] = '{1'b1, 32'h1E, 32'h0,         4'h0, 5'd15, 32'h0};
      vecs[14] = '{1'b1, 32'h0B, 32'h0,         4'h0, 5'd16, 32'h0000_1000};

      periph.req = 1'b0; periph.wen = 1'b0; periph.add = '0;
      periph.data = '0;  periph.be = '0;    periph.id = '0;
      done_i = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset r_valid", {31'd0, periph.r_valid}, 32'd0);
      check("reset r_data", periph.r_data, 32'd0);
      check("reset r_id", {27'd0, periph.r_id}, 32'd0);
      check("reset start_o", {31'd0, start_o}, 32'd0);
      check("reset busy_o", {31'd0, busy_o}, 32'd0);
      rst_ni = 1'b1;
      @(negedge clk);
      check("idle r_valid", {31'd0, periph.r_valid}, 32'd0);

      // Register table
      for (int i = 0; i < 15; i++) begin
         txn(vecs[i].wen, vecs[i].add, vecs[i].data, vecs[i].be, vecs[i].id, 1'b0,
             rdata, rid, rvalid, gnt);
         check($sformatf("vec%0d gnt", i), {31'd0, gnt}, 32'd1);
         check($sformatf("vec%0d r_valid", i), {31'd0, rvalid}, 32'd1);
         check($sformatf("vec%0d r_id", i), {27'd0, rid}, {27'd0, vecs[i].id});
         check($sformatf("vec%0d r_data", i), rdata, vecs[i].exp);
         $display("vec%0d wen=%0b add=0x%02h data=0x%08h be=%h id=%0d -> r_data=0x%08h r_id=%0d",
                  i, vecs[i].wen, vecs[i].add, vecs[i].data, vecs[i].be, vecs[i].id, rdata, rid);
      end
      @(negedge clk);
      check("r_valid one-cycle pulse", {31'd0, periph.r_valid}, 32'd0);
      check("src_a_o", src_a_o, 32'h0000_1000);
      check("src_b_o", src_b_o, 32'h00AD_00EF);
      check("dst_o", dst_o, 32'hFF34_5678);
      check("len_o", {16'd0, len_o}, 32'd8);
      check("mode_o", {30'd0, mode_o}, 32'd3);

      // Job start
      txn(1'b0, 32'h00, 32'h1, 4'hF, 5'd7, 1'b0, rdata, rid, rvalid, gnt);
      t_start = cyc;
      check("trigger r_id", {27'd0, rid}, 32'd7);
      check("trigger r_data", rdata, 32'd0);
      check("start_o pulse", {31'd0, start_o}, 32'd1);
      check("busy_o in START", {31'd0, busy_o}, 32'd1);
      @(negedge clk);
      check("start_o dropped", {31'd0, start_o}, 32'd0);
      check("busy_o in BUSY", {31'd0, busy_o}, 32'd1);
      rd(32'h04, "STATUS busy", 32'h1);
      $display("job started, STATUS busy");

      // Writes while busy
      wr(32'h10, 32'h0000_ABCD, 4'hF);
      wr(32'h00, 32'h1, 4'hF);
      check("dst_o frozen", dst_o, 32'hFF34_5678);
      rd(32'h04, "STATUS busy+err", 32'h5);
      rd(32'h04, "STATUS err cleared", 32'h1);
      check("single start pulse", start_cnt, 1);
      m = 12;
      repeat (m) @(negedge clk);

      // done_i coincident with STATUS read
      txn(1'b1, 32'h04, 32'h0, 4'h0, 5'd20, 1'b1, rdata, rid, rvalid, gnt);
      t_end = cyc;
      check("STATUS at done_i", rdata, 32'h1);
      check("busy_o after done", {31'd0, busy_o}, 32'd0);
      rd(32'h04, "STATUS done", 32'h2);
      rd(32'h04, "STATUS cleared", 32'h0);
`ifdef SNAX_MAC_PERF_CNT_EN
      perf_exp = t_end - t_start;
`else
      perf_exp = 0;
`endif
      rd(32'h1C, "PERF", perf_exp);
      $display("job done after %0d active cycles, PERF expected %0d", t_end - t_start, perf_exp);

      // Zero-length job and out-of-range accesses
      wr(32'h14, 32'h0, 4'hF);
      wr(32'h00, 32'h1, 4'hF);
      check("LEN=0 no start", {31'd0, start_o}, 32'd0);
      check("LEN=0 no busy", {31'd0, busy_o}, 32'd0);
      rd(32'h04, "STATUS LEN=0 done", 32'h2);
      rd(32'h40, "out-of-range read", 32'h0);
      wr(32'h28, 32'h5555_5555, 4'hF);
      rd(32'h04, "STATUS err", 32'h4);
      rd(32'h08, "SRC_A after OOR write", 32'h0000_1000);
      check("start pulses total", start_cnt, 1);

      // Back-to-back reads
      @(negedge clk);
      periph.req = 1'b1; periph.wen = 1'b1; periph.add = 32'h08; periph.id = 5'd1;
      @(negedge clk);
      check("b2b first r_valid", {31'd0, periph.r_valid}, 32'd1);
      check("b2b first r_id", {27'd0, periph.r_id}, 32'd1);
      check("b2b first r_data", periph.r_data, 32'h0000_1000);
      periph.add = 32'h10; periph.id = 5'd2;
      @(negedge clk);
      periph.req = 1'b0;
      check("b2b second r_valid", {31'd0, periph.r_valid}, 32'd1);
      check("b2b second r_id", {27'd0, periph.r_id}, 32'd2);
      check("b2b second r_data", periph.r_data, 32'hFF34_5678);
      $display("back-to-back reads id1/id2 done");

      // Asynchronous reset during START
      wr(32'h14, 32'h4, 4'hF);
      @(negedge clk);
      periph.req = 1'b1; periph.wen = 1'b0; periph.add = 32'h00;
      periph.data = 32'h1; periph.be = 4'hF; periph.id = 5'd3;
      @(posedge clk);
      #2;
      check("pre-reset start_o", {31'd0, start_o}, 32'd1);
      check("pre-reset r_valid", {31'd0, periph.r_valid}, 32'd1);
      rst_ni = 1'b0;
      #1;
      check("async reset start_o", {31'd0, start_o}, 32'd0);
      check("async reset busy_o", {31'd0, busy_o}, 32'd0);
      check("async reset r_valid", {31'd0, periph.r_valid}, 32'd0);
      @(negedge clk);
      periph.req = 1'b0;
      @(negedge clk);
      rst_ni = 1'b1;
      check("post-reset src_a_o", src_a_o, 32'd0);
      check("post-reset len_o", {16'd0, len_o}, 32'd0);
      check("post-reset mode_o", {30'd0, mode_o}, 32'd0);
      for (int w = 0; w < 8; w++) begin
         rd(32'(w * 4), $sformatf("post-reset reg 0x%02h", w * 4), 32'h0);
      end
      $display("reset mid-job: registers cleared");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/snax_mac_periph_regfile.md
Name: snax_mac_periph_regfile

Overview:
- Peripheral-side slave that terminates the HWPE periph bus (32-bit, req/gnt plus r_valid) driven by the SNAX accelerator control stage.
- Holds the MAC job configuration registers and runs a job-control FSM: IDLE, START, BUSY.
- Issues a one-cycle start pulse to the MAC streamer/engine, tracks completion, and exposes status and a cycle count back over the same bus.
- Every granted transaction, read or write, produces exactly one r_valid response.

Parameters:
- IdWidth, 5, width of periph id / r_id.
- LenWidth, 16, significant bits of LEN register (upper bits read 0).
- ModeWidth, 2, significant bits of MODE register.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- periph_req_i  in  1  request valid
- periph_gnt_o  out  1  request granted
- periph_add_i  in  32  byte address
- periph_wen_i  in  1  1 = read, 0 = write
- periph_be_i  in  4  byte enables for writes
- periph_data_i  in  32  write data
- periph_id_i  in  IdWidth  transaction id
- periph_r_valid_o  out  1  response valid
- periph_r_data_o  out  32  read data (0 for writes)
- periph_r_id_o  out  IdWidth  echoed id
- start_o  out  1  one-cycle job start pulse to engine
- src_a_o / src_b_o / dst_o  out  32 each  configured base addresses
- len_o  out  LenWidth  element count
- mode_o  out  ModeWidth  MAC mode
- busy_o  out  1  job in flight
- done_i  in  1  engine completion pulse

Behaviour:
- Clock/reset: one clock, clk_i. rst_ni is asynchronous and active-low.
- Reset values: all registers 0, FSM IDLE, start_o=0, busy_o=0, periph_r_valid_o=0, r_data=0, r_id=0.
- Grant: periph_gnt_o = periph_req_i (combinational, never stalls).
- Response: registered, one cycle after grant. r_valid pulses one cycle. r_id = id of the granted request. Back-to-back requests produce back-to-back responses.
- Decode: word index = add[4:2]. add[1:0] are ignored. If add[31:5] != 0 the access is out of range: read returns 0, write is ignored, err is set.
- Register map:
  - 0x00 CTRL: write with data[0]=1 triggers a job. Reads 0.
  - 0x04 STATUS: read-only. bit0 busy, bit1 done, bit2 err. Reading clears done and err.
  - 0x08 SRC_A, 0x0C SRC_B, 0x10 DST, 0x14 LEN, 0x18 MODE: read/write. Writes honour be per byte. Unused upper bits read 0.
  - 0x1C PERF: read-only cycle count (see optional feature).
- FSM:
  - IDLE: on CTRL trigger with LEN != 0, go to START. On trigger with LEN == 0, set done and stay in IDLE (no start_o).
  - START: start_o=1 for exactly one cycle, busy_o=1. Next state BUSY.
  - BUSY: busy_o=1. On done_i, go to IDLE, set done, busy_o drops the next cycle.
- Writes while busy: trigger or writes to 0x08–0x18 are ignored and set err. Config outputs stay stable for the whole job.
- done_i outside BUSY: ignored.
- Simultaneous done_i and STATUS read in the same cycle: the read returns the pre-update value (busy=1, done=0); done is then set and not lost.
- Simultaneous STATUS read and a new err/done set event: the set wins (the flag stays 1).
- Reset mid-job: immediate return to IDLE, start_o and busy_o drop asynchronously, configuration is cleared.

Optional Feature:
- Macro: SNAX_MAC_PERF_CNT_EN.
- Defined: 32-bit PERF counter cleared on entry to START, increments every cycle in START/BUSY, holds its value in IDLE, saturates at 0xFFFF_FFFF.
- Undefined: no counter logic; PERF reads 0.

Decomposition:
- Package snax_mac_regfile_pkg:
  - register byte-offset localparams,
  - FSM state enum (IDLE, START, BUSY),
  - packed mac_cfg_t struct (src_a, src_b, dst, len, mode).
- Sub-module snax_mac_job_fsm: FSM, done/err flag logic, start pulse, perf counter.
- Top level keeps decode, register storage and the response pipeline.

Test Plan:
- Write SRC_A 0x1000 (be=F, id=3), read back → write r_valid one cycle later with r_data=0, r_id=3; read returns 0x0000_1000.
- Write LEN=8, write CTRL=1 → start_o high exactly one cycle later for one cycle; busy_o=1; STATUS reads 0x1.
- Drive done_i after 20 cycles, then read STATUS twice → first read 0x2, second read 0x0; with SNAX_MAC_PERF_CNT_EN, PERF reads 21.
- While BUSY, write DST=0xABCD and CTRL=1 → dst_o unchanged, no second start_o, STATUS reads 0x5.
- LEN=0 then CTRL=1 → no start_o; STATUS reads 0x2. Read of address 0x40 → r_data=0, next STATUS read has err set.
- Assert rst_ni low mid-BUSY → busy_o, start_o and r_valid go 0 immediately; all registers read 0 after release.
